// File: rtl/fft_fixed_pkg.sv
// Fixed-point formats and helpers shared by the FFT datapath stages.
// Data components are Q6.2 and twiddle components are Q2.6. Both are 8-bit signed.
package fft_fixed_pkg;

   localparam int DATA_W    = 8;
   localparam int FRAC_W    = 2;
   localparam int TW_FRAC_W = 6;

   // Width of one data x twiddle product, the 17-bit sum of two products,
   // and the working width used for rounding and saturation.
   localparam int PROD_W = 2 * DATA_W;
   localparam int PSUM_W = PROD_W + 1;
   localparam int WIDE_W = PSUM_W + 1;

   localparam logic signed [WIDE_W-1:0] ROUND_K = WIDE_W'(2 ** (TW_FRAC_W - 1));

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   // Clamp a wide signed value into the DATA_W range [0x80, 0x7F].
   function automatic logic signed [DATA_W-1:0] sat_to_data(input logic signed [WIDE_W-1:0] v);
      logic [WIDE_W-DATA_W:0] hi;
      hi = v[WIDE_W-1:DATA_W-1];
      if (hi == '0 || hi == '1)
         return v[DATA_W-1:0];
      else if (v[WIDE_W-1])
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   // Drop the twiddle fraction bits, rounding a half toward +inf.
   function automatic logic signed [WIDE_W-1:0] round_shift_tw(input logic signed [PSUM_W-1:0] v);
      logic signed [WIDE_W-1:0] t;
      t = WIDE_W'(v) + ROUND_K;
      return t >>> TW_FRAC_W;
   endfunction

   function automatic logic [2*DATA_W-1:0] pack_cplx(input cplx_t c);
      return {c.re, c.im};
   endfunction

   function automatic cplx_t unpack_cplx(input logic [2*DATA_W-1:0] v);
      cplx_t c;
      c.re = v[2*DATA_W-1:DATA_W];
      c.im = v[DATA_W-1:0];
      return c;
   endfunction

endpackage

// File: rtl/complex_mult_pipe.sv
// Two-stage complex multiplier that computes W*B.
// Stage 1 registers the four partial products.
// Stage 2 combines them, then rounds and saturates back to DATA_W.
// This block holds data only. Valid tracking stays with the caller, which drives i_en.
module complex_mult_pipe
   import fft_fixed_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_en,
   input  logic [2*DATA_W-1:0] i_b,
   input  logic [2*DATA_W-1:0] i_w,
   output logic [2*DATA_W-1:0] o_wb
);

   cplx_t b;
   cplx_t w;
   cplx_t wb_p1;

   logic signed [PROD_W-1:0] prod_rr_p0;
   logic signed [PROD_W-1:0] prod_ii_p0;
   logic signed [PROD_W-1:0] prod_ri_p0;
   logic signed [PROD_W-1:0] prod_ir_p0;

   logic signed [PSUM_W-1:0] sum_re;
   logic signed [PSUM_W-1:0] sum_im;

   assign b = unpack_cplx(i_b);
   assign w = unpack_cplx(i_w);

   // ---- stage 1: partial products ----
   // Capture the four signed partial products whenever the pipeline advances.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         prod_rr_p0 <= PROD_W'($signed(b.re)) * PROD_W'($signed(w.re));
         prod_ii_p0 <= PROD_W'($signed(b.im)) * PROD_W'($signed(w.im));
         prod_ri_p0 <= PROD_W'($signed(b.re)) * PROD_W'($signed(w.im));
         prod_ir_p0 <= PROD_W'($signed(b.im)) * PROD_W'($signed(w.re));
      end
   end

   assign sum_re = PSUM_W'(prod_rr_p0) - PSUM_W'(prod_ii_p0);
   assign sum_im = PSUM_W'(prod_ri_p0) + PSUM_W'(prod_ir_p0);

   // ---- stage 2: combine, round, saturate ----
   // Register W*B in data format once the twiddle fraction has been removed.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         wb_p1.re <= sat_to_data(round_shift_tw(sum_re));
         wb_p1.im <= sat_to_data(round_shift_tw(sum_im));
      end
   end

   assign o_wb = pack_cplx(wb_p1);

endmodule

// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly: X = A + W*B, Y = A - W*B.
// The butterfly is a three-stage pipeline with valid/ready flow control.
// Every stage moves together. When the output is valid and not taken, the whole pipe freezes.
// The outputs are not scaled by 1/2. Scaling is left to the consumer.
module fft_butterfly_r2
   import fft_fixed_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [2*DATA_W-1:0] i_A,
   input  logic [2*DATA_W-1:0] i_B,
   input  logic [2*DATA_W-1:0] i_W,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [2*DATA_W-1:0] o_X,
   output logic [2*DATA_W-1:0] o_Y
);

   logic  advance;
   logic  vld_p0;
   logic  vld_p1;
   logic  vld_p2;
   cplx_t a_p0;
   cplx_t a_p1;
   cplx_t wb_p1;
   cplx_t x_nxt;
   cplx_t y_nxt;
   logic [2*DATA_W-1:0] wb_bits;

   assign advance = i_ready | ~vld_p2;
   assign o_ready = advance;
   assign o_valid = vld_p2;

   complex_mult_pipe u_cmul (
      .i_clk (i_clk),
      .i_en  (advance),
      .i_b   (i_B),
      .i_w   (i_W),
      .o_wb  (wb_bits)
   );

   assign wb_p1 = unpack_cplx(wb_bits);

   // Stage valid bits shift together on advance. Reset drops every in-flight sample.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (advance) begin
         vld_p0 <= i_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // ---- stages 1-2: A delay line, kept aligned with the multiplier ----
   // Delay A so that it meets W*B at the add/sub stage.
   always_ff @(posedge i_clk) begin
      if (advance) begin
         a_p0 <= unpack_cplx(i_A);
         a_p1 <= a_p0;
      end
   end

   // Compute saturated sum and difference of A and W*B for each component.
   always_comb begin
      x_nxt    = '0;
      y_nxt    = '0;
      x_nxt.re = sat_to_data(WIDE_W'($signed(a_p1.re)) + WIDE_W'($signed(wb_p1.re)));
      x_nxt.im = sat_to_data(WIDE_W'($signed(a_p1.im)) + WIDE_W'($signed(wb_p1.im)));
      y_nxt.re = sat_to_data(WIDE_W'($signed(a_p1.re)) - WIDE_W'($signed(wb_p1.re)));
      y_nxt.im = sat_to_data(WIDE_W'($signed(a_p1.im)) - WIDE_W'($signed(wb_p1.im)));
   end

   // ---- stage 3: output registers ----
   // Load outputs only for a real sample, so the last result holds through bubbles and stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_X <= '0;
         o_Y <= '0;
      end else if (advance && vld_p1) begin
         o_X <= pack_cplx(x_nxt);
         o_Y <= pack_cplx(y_nxt);
      end
   end

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Bench for fft_butterfly_r2: directed butterfly cases, backpressure,
// randomized traffic against an integer reference model, and reset mid-flight.
module tb_fft_butterfly_r2;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_A;
   logic [15:0] i_B;
   logic [15:0] i_W;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_X;
   logic [15:0] o_Y;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_in     = 0;
   int          n_out    = 0;
   logic [31:0] exp_q[$];

   fft_butterfly_r2 dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_A     (i_A),
      .i_B     (i_B),
      .i_W     (i_W),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_X     (o_X),
      .o_Y     (o_Y)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: real-number butterfly with Q2.6 twiddle, round half up, clamp to 8 bits.
   function automatic int rnd_tw(input int p);
      int n;
      n = p + 32;
      if (n >= 0) return n / 64;
      else        return -((-n + 63) / 64);
   endfunction

   function automatic int clamp8(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w);
      int ar, ai, br, bi, wr, wi, wbr, wbi, t;
      logic [7:0] xr, xi, yr, yi;
      ar = int'($signed(a[15:8])); ai = int'($signed(a[7:0]));
      br = int'($signed(b[15:8])); bi = int'($signed(b[7:0]));
      wr = int'($signed(w[15:8])); wi = int'($signed(w[7:0]));
      wbr = clamp8(rnd_tw(br * wr - bi * wi));
      wbi = clamp8(rnd_tw(br * wi + bi * wr));
      t = clamp8(ar + wbr); xr = t[7:0];
      t = clamp8(ai + wbi); xi = t[7:0];
      t = clamp8(ar - wbr); yr = t[7:0];
      t = clamp8(ai - wbi); yi = t[7:0];
      return {xr, xi, yr, yi};
   endfunction

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: observe transfers at the negedge, then step to just after the posedge.
   task automatic cycle();
      logic [31:0] e;
      @(negedge i_clk);
      if (i_valid && o_ready) begin
         exp_q.push_back(model(i_A, i_B, i_W));
         n_in++;
      end
      if (o_valid && i_ready) begin
         chk1("sb_expected_output", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk16("sb_X", o_X, e[31:16]);
            chk16("sb_Y", o_Y, e[15:0]);
         end
         n_out++;
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] w, input logic [15:0] ex, input logic [15:0] ey);
      i_A = a; i_B = b; i_W = w; i_valid = 1'b1; i_ready = 1'b1;
      cycle();
      i_valid = 1'b0;
      chk1({tag, "_lat1"}, o_valid, 1'b0);
      cycle();
      chk1({tag, "_lat2"}, o_valid, 1'b0);
      cycle();
      chk1({tag, "_lat3_valid"}, o_valid, 1'b1);
      chk16({tag, "_X"}, o_X, ex);
      chk16({tag, "_Y"}, o_Y, ey);
      cycle();
   endtask

   task automatic backpressure();
      logic [15:0] va[6];
      logic [15:0] vb[6];
      logic [15:0] vw[6];
      logic [15:0] held;
      logic        was_stall;
      int          sent;
      int          out0;
      for (int i = 0; i < 6; i++) begin
         va[i] = 16'($urandom); vb[i] = 16'($urandom); vw[i] = 16'($urandom);
      end
      sent = 0; was_stall = 1'b0; held = '0; out0 = n_out;
      for (int c = 0; c < 30; c++) begin
         i_ready = !(c >= 4 && c <= 7);
         i_valid = (sent < 6);
         if (sent < 6) begin
            i_A = va[sent]; i_B = vb[sent]; i_W = vw[sent];
         end
         #1;
         if (o_valid && !i_ready) begin
            chk1("bp_o_ready_low", o_ready, 1'b0);
            if (was_stall) chk16("bp_X_stable", o_X, held);
            held = o_X;
            was_stall = 1'b1;
         end else begin
            was_stall = 1'b0;
         end
         if (i_valid && o_ready) sent++;
         cycle();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      chk_int("bp_delivered", n_out - out0, 6);
      chk_int("bp_queue_empty", exp_q.size(), 0);
   endtask

   task automatic random_traffic();
      for (int c = 0; c < 80; c++) begin
         i_valid = 1'($urandom_range(0, 1));
         i_ready = ($urandom_range(0, 3) != 0);
         i_A = 16'($urandom); i_B = 16'($urandom); i_W = 16'($urandom);
         cycle();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int c = 0; c < 10; c++) cycle();
      chk_int("rnd_queue_empty", exp_q.size(), 0);
      chk_int("rnd_in_out_count", n_out, n_in);
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_A = '0; i_B = '0; i_W = '0;
      #2;
      chk1("rst_o_valid", o_valid, 1'b0);
      chk16("rst_o_X", o_X, 16'h0000);
      chk16("rst_o_Y", o_Y, 16'h0000);
      #10 i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      chk1("rst_o_ready", o_ready, 1'b1);

      directed("identity",  16'h0AEF, 16'h0D16, 16'h4000, 16'h1705, 16'hFDD9);
      directed("minus_j",   16'h0000, 16'h0400, 16'h00C0, 16'h00FC, 16'h0004);
      directed("sat_pos",   16'h7F00, 16'h7F00, 16'h4000, 16'h7F00, 16'h0000);
      directed("sat_neg",   16'h8000, 16'h7F00, 16'h4000, 16'hFF00, 16'h8000);
      directed("round_tie", 16'h0000, 16'h0100, 16'h2000, 16'h0100, 16'hFF00);
      directed("neg_tie",   16'h0000, 16'hFF00, 16'h2000, 16'h0000, 16'h0000);

      backpressure();
      random_traffic();

      // Leave a nonzero result on the outputs so that clearing it on reset is visible.
      directed("pre_rst", 16'h0AEF, 16'h0D16, 16'h4000, 16'h1705, 16'hFDD9);
      i_ready = 1'b1;
      i_A = 16'($urandom); i_B = 16'($urandom); i_W = 16'($urandom); i_valid = 1'b1;
      cycle();
      i_A = 16'($urandom); i_B = 16'($urandom); i_W = 16'($urandom);
      cycle();
      i_valid = 1'b0;
      #1 i_rst_n = 1'b0;
      #1;
      chk1("midrst_o_valid", o_valid, 1'b0);
      chk16("midrst_o_X", o_X, 16'h0000);
      chk16("midrst_o_Y", o_Y, 16'h0000);
      exp_q.delete();
      #5 i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      for (int c = 0; c < 6; c++) begin
         cycle();
         chk1("midrst_no_stale", o_valid, 1'b0);
      end
      directed("post_rst", 16'h0000, 16'h0400, 16'h00C0, 16'h00FC, 16'h0004);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
